// File: rtl/bmp_cap_pkg.sv
// Shared types and error codes for the BMP frame-capture sequencer.
package bmp_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    CAPTURE,
    CHECK,
    DONE
  } cap_state_e;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_WIDTH = 2'b01;
  localparam logic [1:0] ERR_LINES = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

endpackage

// File: rtl/sync_edge_det.sv
// Registered edge detector: one flop of history, combinational rise/fall strobes.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/bmp_capture_ctrl.sv
// Frame-capture sequencer: skips N frames, gates one frame into the BMP writer,
// then reports geometry errors against HRES x VRES.
module bmp_capture_ctrl
  import bmp_cap_pkg::*;
#(
  parameter int HRES   = 320,
  parameter int VRES   = 240,
  parameter int SKIP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [SKIP_W-1:0]          i_skip,
  input  logic                       i_vsync,
  input  logic                       i_hsync,
  input  logic                       i_de,
  output logic                       o_hdr_wr,
  output logic                       o_cap_en,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [1:0]                 o_err,
  output logic [$clog2(VRES+2)-1:0]  o_line_cnt
);

  localparam int PIX_W  = $clog2(HRES + 2);
  localparam int LINE_W = $clog2(VRES + 2);
  localparam logic [PIX_W-1:0]  HRES_C = PIX_W'(HRES);
  localparam logic [LINE_W-1:0] VRES_C = LINE_W'(VRES);

  cap_state_e         state_q;
  logic [SKIP_W-1:0]  skip_q;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [1:0]         err_q;
  logic               hdr_q, cap_q, busy_q, done_q;
  logic               vs_rise, vs_fall, de_rise, de_fall;

  sync_edge_det u_vs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (i_vsync),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  sync_edge_det u_de_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (i_de),
    .rise_o (de_rise),
    .fall_o (de_fall)
  );

  // hsync is observed only; lines are delimited by de falling edges.
  logic unused_inputs;
  assign unused_inputs = ^{i_hsync, vs_fall, de_rise};

  // Saturating pixel/line counters; a pinned all-ones value never equals HRES/VRES.
  // NOTE: defaults first in always_comb so no latch is inferred.
  always_comb begin
    pix_d  = pix_q;
    line_d = line_q;
    if (state_q == IDLE && i_start) begin
      pix_d  = '0;
      line_d = '0;
    end else if (state_q == CAPTURE && !i_abort) begin
      if (de_fall) begin
        pix_d = '0;
        if (!(&line_q)) line_d = line_q + LINE_W'(1);
      end else if (i_de && cap_q && !(&pix_q)) begin
        pix_d = pix_q + PIX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      skip_q  <= '0;
      pix_q   <= '0;
      line_q  <= '0;
      err_q   <= ERR_OK;
      hdr_q   <= 1'b0;
      cap_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pix_q  <= pix_d;
      line_q <= line_d;
      hdr_q  <= 1'b0;
      done_q <= 1'b0;
      if (i_abort && state_q inside {SKIP, CAPTURE, CHECK}) begin
        state_q <= DONE;
        cap_q   <= 1'b0;
        err_q   <= ERR_ABORT;
        done_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (i_start) begin
              state_q <= SKIP;
              skip_q  <= i_skip;
              err_q   <= ERR_OK;
              busy_q  <= 1'b1;
            end
          end
          SKIP: begin
            if (vs_rise) begin
              if (skip_q == '0) begin
                state_q <= CAPTURE;
                hdr_q   <= 1'b1;
                cap_q   <= 1'b1;
              end else begin
                skip_q <= skip_q - SKIP_W'(1);
              end
            end
          end
          CAPTURE: begin
            // A line ending on the closing vsync edge is still width-checked here.
            if (de_fall && pix_q != HRES_C && err_q == ERR_OK) err_q <= ERR_WIDTH;
            if (vs_rise) begin
              state_q <= CHECK;
              cap_q   <= 1'b0;
            end
          end
          CHECK: begin
            if (line_q != VRES_C && err_q == ERR_OK) err_q <= ERR_LINES;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_hdr_wr   = hdr_q;
  assign o_cap_en   = cap_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_line_cnt = line_q;

endmodule

// File: tb/tb_bmp_capture_ctrl.sv
// Self-checking bench for bmp_capture_ctrl: a scaled-down raster with randomized
// frame contents, checked against a line-list model of the capture rules.
module tb_bmp_capture_ctrl;
  import bmp_cap_pkg::*;

  localparam int HRES   = 20;
  localparam int VRES   = 12;
  localparam int SKIP_W = 8;
  localparam int LINE_W = $clog2(VRES + 2);
  localparam int PMAX   = (1 << $clog2(HRES + 2)) - 1;
  localparam int LMAX   = (1 << LINE_W) - 1;
  localparam int VP = 3, VB = 3, VF = 5;
  localparam int HP = 3, HB = 3, HF = 5;

  typedef int lens_t[$];

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_start = 1'b0, i_abort = 1'b0, i_vsync = 1'b0, i_hsync = 1'b0, i_de = 1'b0;
  logic [SKIP_W-1:0] i_skip = '0;
  logic o_hdr_wr, o_cap_en, o_busy, o_done;
  logic [1:0] o_err;
  logic [LINE_W-1:0] o_line_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int gated_pix = 0, hdr_cnt = 0, done_cnt = 0, rise_cnt = 0, hdr_rise_idx = 0;
  bit hdr_after_rise = 1'b0, last_rise = 1'b0, vs_prev = 1'b0;

  always #5 clk = ~clk;

  bmp_capture_ctrl #(.HRES(HRES), .VRES(VRES), .SKIP_W(SKIP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_skip     (i_skip),
    .i_vsync    (i_vsync),
    .i_hsync    (i_hsync),
    .i_de       (i_de),
    .o_hdr_wr   (o_hdr_wr),
    .o_cap_en   (o_cap_en),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_line_cnt (o_line_cnt)
  );

  // Writer-side view: pixels actually gated, header pulses and their timing, done pulses.
  always @(negedge clk) begin
    if (i_de && o_cap_en) gated_pix <= gated_pix + 1;
    if (o_hdr_wr) begin
      hdr_cnt        <= hdr_cnt + 1;
      hdr_after_rise <= last_rise;
      hdr_rise_idx   <= rise_cnt;
    end
    if (o_done) done_cnt <= done_cnt + 1;
    last_rise <= i_vsync && !vs_prev;
    if (i_vsync && !vs_prev) rise_cnt <= rise_cnt + 1;
    vs_prev <= i_vsync;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got no summary, want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input bit vs, input int de_len, input int fp);
    i_vsync = vs; i_hsync = 1'b1; i_de = 1'b0;
    repeat (HP) step();
    i_hsync = 1'b0;
    repeat (HB) step();
    i_de = 1'b1;
    repeat (de_len) step();
    i_de = 1'b0;
    repeat (fp) step();
  endtask

  // One raster frame; lens holds de cycles per active line (0 = dropped burst).
  // stop_line >= 0 returns at the start of that line; tight ends the last de burst
  // exactly where the next frame's vsync begins.
  task automatic drive_frame(input lens_t lens, input int stop_line, input bit tight);
    for (int v = 0; v < VP; v++) drive_line(1'b1, 0, HF);
    for (int v = 0; v < VB; v++) drive_line(1'b0, 0, HF);
    for (int l = 0; l < lens.size(); l++) begin
      if (l == stop_line) return;
      drive_line(1'b0, lens[l], (tight && l == lens.size() - 1) ? 0 : HF);
    end
    if (!tight) for (int v = 0; v < VF; v++) drive_line(1'b0, 0, HF);
  endtask

  function automatic lens_t clean_frame(input int n);
    lens_t q;
    for (int i = 0; i < n; i++) q.push_back(HRES);
    return q;
  endfunction

  function automatic int model_lines(input lens_t lens);
    int n = 0;
    foreach (lens[i]) if (lens[i] > 0) n++;
    return (n > LMAX) ? LMAX : n;
  endfunction

  function automatic int model_err(input lens_t lens);
    foreach (lens[i])
      if (lens[i] > 0 && ((lens[i] > PMAX) ? PMAX : lens[i]) != HRES) return 1;
    if (model_lines(lens) != VRES) return 2;
    return 0;
  endfunction

  function automatic int model_pix(input lens_t lens);
    int s = 0;
    foreach (lens[i]) s += lens[i];
    return s;
  endfunction

  task automatic do_capture(input string tag, input int skip, input lens_t lens,
                            input bit tight, input bit with_abort);
    int rb, pb, hb, db, exp_err, exp_lines, exp_pix;
    lens_t blank;
    exp_err   = model_err(lens);
    exp_lines = model_lines(lens);
    exp_pix   = model_pix(lens);
    i_skip = SKIP_W'(skip); i_start = 1'b1; i_abort = with_abort;
    step();
    i_start = 1'b0; i_abort = 1'b0; i_skip = '0;
    n_checks++;
    if (o_busy !== 1'b1 || o_err !== ERR_OK) begin
      n_fail++;
      $display("FAIL %s start: busy=%b err=%b, want busy=1 err=00", tag, o_busy, o_err);
    end
    rb = rise_cnt; pb = gated_pix; hb = hdr_cnt; db = done_cnt;
    for (int f = 0; f < skip; f++) drive_frame(clean_frame(VRES), -1, 1'b0);
    drive_frame(lens, -1, tight);
    drive_frame(blank, -1, 1'b0);
    n_checks++;
    if (hdr_cnt - hb != 1 || !hdr_after_rise || hdr_rise_idx - rb != skip + 1) begin
      n_fail++;
      $display("FAIL %s hdr_wr: pulses=%0d after_rise=%b on_rise=%0d, want 1 1 %0d",
               tag, hdr_cnt - hb, hdr_after_rise, hdr_rise_idx - rb, skip + 1);
    end
    n_checks++;
    if (gated_pix - pb != exp_pix) begin
      n_fail++;
      $display("FAIL %s gated_pix: got %0d want %0d", tag, gated_pix - pb, exp_pix);
    end
    n_checks++;
    if (done_cnt - db != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt - db);
    end
    n_checks++;
    if (o_err !== 2'(exp_err)) begin
      n_fail++;
      $display("FAIL %s err: got %0d want %0d", tag, o_err, exp_err);
    end
    n_checks++;
    if (o_line_cnt !== LINE_W'(exp_lines)) begin
      n_fail++;
      $display("FAIL %s line_cnt: got %0d want %0d", tag, o_line_cnt, exp_lines);
    end
    n_checks++;
    if (o_busy !== 1'b0 || o_cap_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: busy=%b cap_en=%b, want 0 0", tag, o_busy, o_cap_en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if (o_hdr_wr !== 1'b0 || o_cap_en !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset pulses: hdr=%b cap=%b done=%b, want 0", o_hdr_wr, o_cap_en, o_done);
    end
    n_checks++;
    if (o_busy !== 1'b0 || o_err !== 2'b00 || o_line_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset state: busy=%b err=%b lines=%0d, want 0", o_busy, o_err, o_line_cnt);
    end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_basic();
    do_capture("basic", 0, clean_frame(VRES), 1'b0, 1'b0);
  endtask

  task automatic test_skip();
    do_capture("skip", int'($urandom_range(1, 3)), clean_frame(VRES), 1'b0, 1'b0);
  endtask

  task automatic test_width_err();
    lens_t f = clean_frame(VRES);
    int idx = $urandom_range(0, VRES - 3);
    f[idx] = HRES - 1;
    f.delete(VRES - 1);
    do_capture("width_err", 0, f, 1'b0, 1'b0);
  endtask

  task automatic test_line_err();
    lens_t f = clean_frame(VRES);
    f[$urandom_range(0, VRES - 1)] = 0;
    do_capture("line_err", 0, f, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    lens_t f = clean_frame(VRES);
    f[$urandom_range(0, VRES - 1)] = PMAX + 1 + HRES;
    do_capture("pix_sat", 0, f, 1'b0, 1'b0);
    do_capture("line_sat", 0, clean_frame(LMAX + 1 + VRES), 1'b0, 1'b0);
  endtask

  task automatic test_tight();
    lens_t f = clean_frame(VRES);
    do_capture("tight_ok", 0, f, 1'b1, 1'b0);
    f[VRES - 1] = HRES - 1;
    do_capture("tight_short", 0, f, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    int stop = $urandom_range(2, VRES - 2);
    int db;
    i_skip = '0; i_start = 1'b1; step(); i_start = 1'b0;
    db = done_cnt;
    drive_frame(clean_frame(VRES), stop, 1'b0);
    n_checks++;
    if (o_cap_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort pre: cap_en=%b want 1", o_cap_en);
    end
    i_abort = 1'b1; step();
    i_abort = 1'b0; i_start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_cap_en !== 1'b0 || o_done !== 1'b1 || o_err !== ERR_ABORT || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort done: cap=%b done=%b err=%b busy=%b, want 0 1 11 1",
               o_cap_en, o_done, o_err, o_busy);
    end
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== ERR_ABORT) begin
      n_fail++;
      $display("FAIL abort start_in_done: busy=%b done=%b err=%b, want 0 0 11", o_busy, o_done, o_err);
    end
    i_abort = 1'b1; step(); step(); i_abort = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0 || o_err !== ERR_ABORT || done_cnt - db != 1) begin
      n_fail++;
      $display("FAIL abort idle_ignored: busy=%b err=%b dones=%0d, want 0 11 1", o_busy, o_err, done_cnt - db);
    end
    do_capture("abort_restart", 0, clean_frame(VRES), 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int db = done_cnt, hb = hdr_cnt, pb = gated_pix;
    lens_t blank;
    i_skip = SKIP_W'(2); i_start = 1'b1; step(); i_start = 1'b0; i_skip = '0;
    drive_frame(clean_frame(VRES), -1, 1'b0);
    drive_frame(clean_frame(VRES), 3, 1'b0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_checks++;
    if ({o_hdr_wr, o_cap_en, o_busy, o_done, o_err, o_line_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rst_skip outputs: hdr=%b cap=%b busy=%b done=%b err=%b lines=%0d, want all 0",
               o_hdr_wr, o_cap_en, o_busy, o_done, o_err, o_line_cnt);
    end
    drive_frame(clean_frame(VRES), -1, 1'b0);
    drive_frame(clean_frame(VRES), -1, 1'b0);
    n_checks++;
    if (hdr_cnt != hb || gated_pix != pb || done_cnt != db) begin
      n_fail++;
      $display("FAIL rst_skip after: hdr=%0d pix=%0d done=%0d, want 0 0 0",
               hdr_cnt - hb, gated_pix - pb, done_cnt - db);
    end
    i_start = 1'b1; step(); i_start = 1'b0;
    drive_frame(clean_frame(VRES), 5, 1'b0);
    n_checks++;
    if (o_cap_en !== 1'b1 || o_line_cnt !== LINE_W'(5)) begin
      n_fail++;
      $display("FAIL rst_cap pre: cap=%b lines=%0d, want 1 5", o_cap_en, o_line_cnt);
    end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_checks++;
    if ({o_hdr_wr, o_cap_en, o_busy, o_done, o_err, o_line_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rst_cap outputs: hdr=%b cap=%b busy=%b done=%b err=%b lines=%0d, want all 0",
               o_hdr_wr, o_cap_en, o_busy, o_done, o_err, o_line_cnt);
    end
    drive_frame(blank, -1, 1'b0);
    n_checks++;
    if (done_cnt != db || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cap after: dones=%0d busy=%b, want 0 0", done_cnt - db, o_busy);
    end
  endtask

  task automatic test_busy_start();
    int hb = hdr_cnt, db = done_cnt, rb;
    lens_t blank;
    i_skip = SKIP_W'(1); i_start = 1'b1; step(); i_start = 1'b0; i_skip = '0;
    rb = rise_cnt;
    drive_frame(clean_frame(VRES), 4, 1'b0);
    i_skip = SKIP_W'(3); i_start = 1'b1; step(); i_start = 1'b0; i_skip = '0;
    drive_frame(clean_frame(VRES), -1, 1'b0);
    drive_frame(blank, -1, 1'b0);
    n_checks++;
    if (hdr_cnt - hb != 1 || hdr_rise_idx - rb != 2) begin
      n_fail++;
      $display("FAIL busy_start hdr: pulses=%0d on_rise=%0d, want 1 2", hdr_cnt - hb, hdr_rise_idx - rb);
    end
    n_checks++;
    if (done_cnt - db != 1 || o_err !== ERR_OK || o_line_cnt !== LINE_W'(VRES)) begin
      n_fail++;
      $display("FAIL busy_start result: dones=%0d err=%b lines=%0d, want 1 00 %0d",
               done_cnt - db, o_err, o_line_cnt, VRES);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      lens_t f;
      int n = VRES - 1 + int'($urandom_range(0, 2));
      for (int l = 0; l < n; l++)
        f.push_back(($urandom_range(0, 5) == 0) ? int'($urandom_range(HRES - 2, HRES + 2)) : HRES);
      do_capture($sformatf("random%0d", it), int'($urandom_range(0, 1)), f,
                 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_width_err();
    test_line_err();
    test_saturate();
    test_tight();
    test_abort();
    test_reset_mid();
    test_busy_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
